// File: rtl/pcm_sample_pacer.sv
// Sample FIFO that releases one signed PCM sample every SAMPLE_DIV clocks,
// scaled by an unsigned Q1.7 gain with saturation, for the PWM converter.
module pcm_sample_pacer #(
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 2048
) (
  input  logic                      pwm_clk,
  input  logic                      rst,
  input  logic signed [15:0]        s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic        [7:0]         gain,
  input  logic                      clr_underflow,
  output logic signed [15:0]        pcm_out,
  output logic                      pcm_valid,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      underflow,
  output logic                      underflow_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  logic signed [15:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;
  logic               tick_p0;
  logic               push_p0;
  logic               pop_p0;
  logic               empty_p0;
  logic signed [15:0] head_p0;

  // Q1.7 scaling: 25-bit signed product, arithmetic >>> 7, clamp to 16 bits.
  function automatic logic signed [15:0] sat_scale(input logic signed [15:0] x,
                                                   input logic        [7:0]  g);
    logic signed [24:0] prod;
    logic signed [17:0] shr;
    prod = x * $signed({1'b0, g});
    shr  = prod[24:7];
    if (shr > 18'sd32767)
      sat_scale = 16'sh7FFF;
    else if (shr < -18'sd32768)
      sat_scale = 16'sh8000;
    else
      sat_scale = shr[15:0];
  endfunction

  assign s_ready  = (fifo_level != (AW+1)'(DEPTH));
  assign empty_p0 = (fifo_level == '0);
  assign tick_p0  = (cnt == CW'(SAMPLE_DIV - 1));
  assign push_p0  = s_valid && s_ready;
  assign pop_p0   = tick_p0 && !empty_p0;
  assign head_p0  = mem[rd_ptr];

  // Sample storage carries no reset; the pointers define what is valid.
  always_ff @(posedge pwm_clk) begin
    if (push_p0)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge pwm_clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      cnt <= tick_p0 ? '0 : cnt + 1'b1;
      if (push_p0)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Output stage: one cycle after tick; pcm_out holds on underflow to avoid a click.
  always_ff @(posedge pwm_clk or posedge rst) begin
    if (rst) begin
      pcm_out          <= '0;
      pcm_valid        <= 1'b0;
      underflow        <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      pcm_valid <= tick_p0;
      underflow <= tick_p0 && empty_p0;
      if (pop_p0)
        pcm_out <= sat_scale(head_p0, gain);
      if (tick_p0 && empty_p0)
        underflow_sticky <= 1'b1;
      else if (clr_underflow)
        underflow_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcm_sample_pacer.sv
// Randomized and directed bench for pcm_sample_pacer with a queue-based reference
// model; expected releases go to a scoreboard drained by an independent monitor.
module tb_pcm_sample_pacer;
  localparam int DEPTH = 16;
  localparam int SD    = 4;

  logic               pwm_clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic        [7:0]  gain = 8'd128;
  logic               clr_underflow = 1'b0;
  logic signed [15:0] pcm_out;
  logic               pcm_valid;
  logic        [4:0]  fifo_level;
  logic               underflow;
  logic               underflow_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pwm_clk = ~pwm_clk;

  pcm_sample_pacer #(.DEPTH(DEPTH), .SAMPLE_DIV(SD)) dut (
    .pwm_clk          (pwm_clk),
    .rst              (rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .gain             (gain),
    .clr_underflow    (clr_underflow),
    .pcm_out          (pcm_out),
    .pcm_valid        (pcm_valid),
    .fifo_level       (fifo_level),
    .underflow        (underflow),
    .underflow_sticky (underflow_sticky)
  );

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: released value = clamp(floor(sample * gain / 128)).
  function automatic logic signed [15:0] ref_scale(input logic signed [15:0] x,
                                                   input logic        [7:0]  g);
    int p;
    p = int'(x) * int'(g);
    p = p >>> 7;
    if (p > 32767)  return 16'sh7FFF;
    if (p < -32768) return 16'sh8000;
    return 16'(p);
  endfunction

  logic signed [15:0] mq[$];
  logic signed [15:0] sb[$];
  int                 n_edge   = 0;
  logic signed [15:0] m_last   = '0;
  logic               m_sticky = 1'b0;
  logic               m_valid  = 1'b0;
  logic               m_unf    = 1'b0;
  bit                 m_tick;
  bit                 m_full;

  // Every SD-th edge after reset release is a release edge.
  always @(posedge pwm_clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      sb.delete();
      n_edge   = 0;
      m_last   = '0;
      m_sticky = 1'b0;
      m_valid  = 1'b0;
      m_unf    = 1'b0;
    end else begin
      n_edge++;
      m_tick  = (n_edge % SD) == 0;
      m_full  = mq.size() >= DEPTH;
      m_valid = m_tick;
      m_unf   = 1'b0;
      if (m_tick) begin
        if (mq.size() > 0) m_last = ref_scale(mq.pop_front(), gain);
        else               m_unf  = 1'b1;
        sb.push_back(m_last);
      end
      if (m_unf)              m_sticky = 1'b1;
      else if (clr_underflow) m_sticky = 1'b0;
      if (s_valid && !m_full) mq.push_back(s_data);
    end
  end

  logic signed [15:0] exp_out;

  always @(posedge pwm_clk) begin
    #2;
    if (rst) begin
      chk("rst_pcm_out",    pcm_out, 0);
      chk("rst_pcm_valid",  pcm_valid, 0);
      chk("rst_underflow",  underflow, 0);
      chk("rst_sticky",     underflow_sticky, 0);
      chk("rst_fifo_level", fifo_level, 0);
      chk("rst_s_ready",    s_ready, 1);
    end else begin
      chk("fifo_level", fifo_level, mq.size());
      chk("s_ready",    s_ready, (mq.size() < DEPTH) ? 1 : 0);
      chk("sticky",     underflow_sticky, m_sticky);
      chk("pcm_valid",  pcm_valid, m_valid);
      chk("underflow",  underflow, m_unf);
      if (pcm_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: pcm_out %0d with no expected sample at %0t",
                   pcm_out, $time);
        end else begin
          exp_out = sb.pop_front();
          chk("pcm_out", pcm_out, exp_out);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge pwm_clk);
  endtask

  task automatic push(input logic [15:0] d);
    int  g = 0;
    logic rdy;
    s_data  = d;
    s_valid = 1'b1;
    do begin
      rdy = s_ready;
      step();
      g++;
    end while (!rdy && g < 200);
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: s_ready stayed 0, required 1 within 200 cycles");
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int g = 0;
    while ((n_edge % SD) != ph && g < 50) begin
      step();
      g++;
    end
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(12);

    clr_underflow = 1'b1; step(); clr_underflow = 1'b0;
    push(16'h1000); push(16'h8000); push(16'h7FFF);
    step(16);

    gain = 8'd255;
    push(16'h4000); push(16'hC000); push(16'h7FFF); push(16'h8000);
    step(20);
    gain = 8'd64;
    push(16'h0003);
    step(8);
    gain = 8'd0;
    push(16'h1234); push(16'h8000);
    step(12);

    gain = 8'd128;
    for (int i = 0; i < 24; i++) push(16'($urandom));
    step(80);

    wait_phase(0);
    clr_underflow = 1'b1; step(); clr_underflow = 1'b0;
    step(2);
    wait_phase(SD - 1);
    clr_underflow = 1'b1; step(); clr_underflow = 1'b0;
    step(4);

    for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pcm_out", pcm_out, 0);
    chk("async_rst_level",   fifo_level, 0);
    step();
    rst = 1'b0;
    step(12);

    for (int i = 0; i < 400; i++) begin
      if (i < 200) s_valid = ($urandom_range(0, 3) != 0);
      else         s_valid = ($urandom_range(0, 7) == 0);
      s_data        = 16'($urandom);
      clr_underflow = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) gain = 8'($urandom);
      step();
    end
    s_valid = 1'b0;
    clr_underflow = 1'b0;
    step(80);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pcm_sample_pacer.md
Name: pcm_sample_pacer

Overview:
- Buffers signed 16-bit PCM samples written by the synth/MicroBlaze side and releases exactly one sample every SAMPLE_DIV clocks.
- Applies a Q1.7 volume gain with saturation to each released sample.
- Outputs pcm_out plus a single-cycle pcm_valid strobe. These drive the PCM-to-PWM converter directly, in the same PWM clock domain.

Parameters:
- DEPTH, 16: FIFO depth in samples; power of two, at least 2.
- SAMPLE_DIV, 2048: clocks per output sample; at least 2 (100 MHz / 2048 ≈ 48.8 kHz).

Ports:
- pwm_clk  in  1  PWM-domain clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  16  signed PCM sample to enqueue.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  FIFO can accept; combinational, equals !full.
- gain  in  8  unsigned Q1.7 gain; 128 = unity; sampled at tick.
- clr_underflow  in  1  clears underflow_sticky.
- pcm_out  out  16  signed scaled sample.
- pcm_valid  out  1  single-cycle strobe, pcm_out is new.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- underflow  out  1  single-cycle pulse, tick found FIFO empty.
- underflow_sticky  out  1  latched underflow flag.

Behaviour:
- Reset (asynchronous, rst high):
  - FIFO empty; fifo_level=0; rate counter=0.
  - pcm_out=16'h0000, pcm_valid=0, underflow=0, underflow_sticky=0.
  - s_ready reads 1 during reset, but pushes are ignored while rst is high.
- Push:
  - On a clock edge with s_valid && s_ready, s_data is written at the write pointer, which then advances.
  - Pointers wrap modulo DEPTH.
  - While full, s_ready=0 and s_data is not stored; the source must hold.
- Rate counter:
  - Counts 0..SAMPLE_DIV-1, then wraps to 0.
  - tick = (count == SAMPLE_DIV-1).
  - The first tick after reset release is at the edge SAMPLE_DIV-1 cycles after release, so the first pcm_valid is high in the cycle following the SAMPLE_DIV-th edge.
  - Inter-strobe spacing is exactly SAMPLE_DIV cycles.
- Tick with FIFO non-empty:
  - Pop the head and register pcm_out = sat16((head * $signed({1'b0,gain})) >>> 7).
  - Product is 25-bit signed; the shift is arithmetic.
  - Saturation clamps to the range 16'h8000..16'h7FFF.
  - pcm_valid=1 for exactly the following cycle, giving one cycle of latency from tick.
- Tick with FIFO empty:
  - pcm_out holds its previous value (avoids a click).
  - pcm_valid still pulses.
  - underflow=1 for one cycle and underflow_sticky is set.
- Simultaneous push and pop:
  - Both are performed and the level is unchanged.
  - When full, the push is blocked because s_ready=0; the pop proceeds and s_ready rises the next cycle.
  - When empty, there is no bypass: the tick underflows and the pushed sample is stored for the next tick.
- fifo_level updates on the same edge as the push/pop. It equals write pointer minus read pointer, with an extra wrap bit to distinguish full from empty.
- Sticky flag: set and clr_underflow in the same cycle leaves it set.
- Reset mid-operation: all state is cleared immediately and buffered samples are discarded. Cadence restarts from count 0.
- Outputs other than s_ready are registered.

Test Plan:
1. Reset, then idle with no pushes:
   - During reset: all outputs at reset values, fifo_level=0.
   - With SAMPLE_DIV=4, pcm_valid pulses every 4 cycles, pcm_out=0, underflow pulses and the sticky flag is set.
2. SAMPLE_DIV=4, gain=128, push 16'h1000, 16'h8000, 16'h7FFF:
   - Three pcm_valid strobes exactly 4 cycles apart with pcm_out in that order.
   - fifo_level steps 3→2→1→0.
3. Gain arithmetic, samples pushed at the stated gain:
   - gain=255: 16'h4000 → 16'h7F80; 16'hC000 → 16'h8080; 16'h7FFF → 16'h7FFF (saturated); 16'h8000 → 16'h8000 (saturated).
   - gain=64: 16'h0003 → 16'h0001.
   - gain=0: any sample → 0.
4. Fill test, DEPTH=16, hold s_valid for 18 samples with no tick:
   - s_ready falls after 16 accepts; fifo_level=16.
   - At the next tick: one pop, level 15, s_ready=1 the following cycle, and the 17th sample is accepted.
5. Underflow/clear:
   - Drain the FIFO, then let a tick pass: pcm_out holds the last value, underflow pulses one cycle, sticky=1.
   - Pulse clr_underflow alone: sticky=0.
   - Pulse clr_underflow in the same cycle as a new underflow: sticky stays 1.
6. Async reset mid-stream, 5 samples buffered:
   - Assert rst between clock edges: pcm_out=0, fifo_level=0 immediately.
   - After release, the first pcm_valid arrives after SAMPLE_DIV edges and underflows, since the buffered data was discarded.
